// File: rtl/interfpga_pkg.sv
// Shared constants and types for the inter-FPGA nibble-link scheduler family.
package interfpga_pkg;

  localparam int         BYTE_W    = 8;
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_SEND,
    ST_HDR_WAIT,
    ST_DAT_SEND,
    ST_DAT_WAIT,
    ST_DONE
  } state_e;

  // Header byte: magic nibble on top, requester id in the low nibble.
  function automatic logic [BYTE_W-1:0] hdr_byte(input logic [3:0] id);
    return {HDR_MAGIC, id};
  endfunction

endpackage

// File: rtl/interfpga_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i (mod NUM_REQ).
module interfpga_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = |req_i;
    sum   = '0;
    idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      sum = {1'b0, ptr_i} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/interfpga_tx_scheduler.sv
// Round-robin scheduler framing requester bytes onto one interfpga_send link.
module interfpga_tx_scheduler
  import interfpga_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter bit HEADER_EN = 1'b1,
  parameter int TIMEOUT   = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][BYTE_W-1:0] data_i,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [BYTE_W-1:0]              link_data_o,
  output logic                           link_send_o,
  input  logic                           link_busy_i,
  output logic                           active_o,
  output logic                           err_o,
  input  logic                           err_clr_i
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BYTE_W-1:0]  dat_q, dat_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               seen_busy_q, seen_busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] pk_gnt;
  logic [ID_W-1:0]    pk_id;
  logic               pk_any;

  interfpga_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pk_gnt),
    .id_o  (pk_id),
    .any_o (pk_any)
  );

  // Next-state and output logic; link_data_o is held through the wait so the
  // transmitter sees a stable byte until busy drops.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    dat_d       = dat_q;
    grant_d     = grant_q;
    seen_busy_d = seen_busy_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    ack_o       = '0;
    link_send_o = 1'b0;
    link_data_o = '0;
    if (err_clr_i) err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pk_any) begin
          id_d    = pk_id;
          dat_d   = data_i[pk_id];
          grant_d = pk_gnt;
          state_d = HEADER_EN ? ST_HDR_SEND : ST_DAT_SEND;
        end
      end
      ST_HDR_SEND, ST_DAT_SEND: begin
        link_send_o = 1'b1;
        link_data_o = (state_q == ST_HDR_SEND) ? hdr_byte(4'(id_q)) : dat_q;
        seen_busy_d = 1'b0;
        cnt_d       = '0;
        state_d     = (state_q == ST_HDR_SEND) ? ST_HDR_WAIT : ST_DAT_WAIT;
      end
      ST_HDR_WAIT, ST_DAT_WAIT: begin
        link_data_o = (state_q == ST_HDR_WAIT) ? hdr_byte(4'(id_q)) : dat_q;
        if (link_busy_i) seen_busy_d = 1'b1;
        if (seen_busy_q && !link_busy_i) begin
          state_d = (state_q == ST_HDR_WAIT) ? ST_DAT_SEND : ST_DONE;
        end else if (!seen_busy_q && !link_busy_i) begin
          // Transmitter never acknowledged the strobe: abandon the frame.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        ack_o    = grant_q;
        rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        grant_d  = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      dat_q       <= '0;
      grant_q     <= '0;
      seen_busy_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      dat_q       <= dat_d;
      grant_q     <= grant_d;
      seen_busy_q <= seen_busy_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign grant_o  = grant_q;
  assign active_o = (state_q != ST_IDLE);
  assign err_o    = err_q;

endmodule

// File: tb/tb_interfpga_tx_scheduler.sv
// Directed bench: DUT 0 with header framing, DUT 1 payload-only, each with a busy model.
module tb_interfpga_tx_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][3:0]      req  = '0;
  logic [1:0][3:0][7:0] data = '0;
  logic [1:0]           eclr = '0;
  wire  [1:0][3:0]      ack, grant;
  wire  [1:0][7:0]      ldata;
  wire  [1:0]           send, active, err, busy;

  int busy_len [2] = '{4, 4};
  int bcnt [2];

  interfpga_tx_scheduler #(.NUM_REQ(4), .HEADER_EN(1'b1), .TIMEOUT(8)) u_hdr (
    .clk(clk), .reset_n(rst_n), .req_i(req[0]), .data_i(data[0]), .ack_o(ack[0]),
    .grant_o(grant[0]), .link_data_o(ldata[0]), .link_send_o(send[0]),
    .link_busy_i(busy[0]), .active_o(active[0]), .err_o(err[0]), .err_clr_i(eclr[0]));

  interfpga_tx_scheduler #(.NUM_REQ(4), .HEADER_EN(1'b0), .TIMEOUT(8)) u_nohdr (
    .clk(clk), .reset_n(rst_n), .req_i(req[1]), .data_i(data[1]), .ack_o(ack[1]),
    .grant_o(grant[1]), .link_data_o(ldata[1]), .link_send_o(send[1]),
    .link_busy_i(busy[1]), .active_o(active[1]), .err_o(err[1]), .err_clr_i(eclr[1]));

  // Link model: busy rises the cycle after a strobe for busy_len cycles (0 = never).
  always @(posedge clk or negedge rst_n)
    for (int d = 0; d < 2; d++)
      if (!rst_n)             bcnt[d] <= 0;
      else if (send[d])       bcnt[d] <= busy_len[d];
      else if (bcnt[d] != 0)  bcnt[d] <= bcnt[d] - 1;
  assign busy[0] = (bcnt[0] != 0);
  assign busy[1] = (bcnt[1] != 0);

  // Record every strobed byte and count back-to-back strobes.
  logic [7:0] sent_q[$];
  int         adj_viol = 0;
  logic [1:0] prev_send = '0;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (send[d]) sent_q.push_back(ldata[d]);
      if (send[d] && prev_send[d]) adj_viol++;
    end
    prev_send = send;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input int d, input int limit, output int id, output int cyc);
    id = -1; cyc = 0;
    while (id < 0 && cyc < limit) begin
      @(negedge clk); cyc++;
      for (int i = 0; i < 4; i++) if (ack[d][i]) id = i;
    end
    if (id < 0) chk("ack_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  typedef struct {
    int         sel;
    logic [3:0] req;
    logic [7:0] dat;
    int         busy;
    int         nstr;
    logic [7:0] b0, b1;
    int         ack_cyc;
  } vec_t;
  vec_t vt[6];

  // Single-requester transfer; data is corrupted and req dropped after grant.
  task automatic run_vec(input vec_t v);
    int d, id, cyc, got;
    d = v.sel; id = 0; cyc = 0; got = 0;
    for (int i = 0; i < 4; i++) if (v.req[i]) id = i;
    busy_len[d] = v.busy;
    data[d][id] = v.dat;
    req[d] = v.req;
    sent_q.delete();
    while (!got && cyc < 100) begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin
        chk("vec_grant", grant[d], v.req);
        chk("vec_active", active[d], 1);
      end
      if (cyc == 2) data[d][id] = ~v.dat;
      if (cyc == 3) req[d] = '0;
      if (ack[d] != 0) begin
        got = 1;
        chk("vec_ack_mask", ack[d], v.req);
        chk("vec_ack_cycle", cyc, v.ack_cyc);
      end
    end
    if (!got) chk("vec_ack_seen", 0, 1);
    chk("vec_nstrobe", sent_q.size(), v.nstr);
    if (sent_q.size() >= 1) chk("vec_byte0", sent_q[0], v.b0);
    if (v.nstr == 2 && sent_q.size() >= 2) chk("vec_byte1", sent_q[1], v.b1);
    @(negedge clk);
  endtask

  initial begin
    int id, cyc;
    logic [7:0] exp_hdr [4];
    vt[0] = '{0, 4'b0010, 8'h5C, 4, 2, 8'hA1, 8'h5C, 13};
    vt[1] = '{0, 4'b1000, 8'h3E, 1, 2, 8'hA3, 8'h3E, 7};
    vt[2] = '{0, 4'b0001, 8'h00, 2, 2, 8'hA0, 8'h00, 9};
    vt[3] = '{0, 4'b0100, 8'hC7, 4, 2, 8'hA2, 8'hC7, 13};
    vt[4] = '{1, 4'b0100, 8'hFF, 4, 1, 8'hFF, 8'h00, 7};
    vt[5] = '{1, 4'b0001, 8'h5A, 2, 1, 8'h5A, 8'h00, 5};

    // Reset state
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", ack[d], 0);
      chk("rst_grant", grant[d], 0);
      chk("rst_ldata", ldata[d], 0);
      chk("rst_send", send[d], 0);
      chk("rst_active", active[d], 0);
      chk("rst_err", err[d], 0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(vt[k]);

    // All four at once from rr_ptr=0: service 0,1,2,3
    busy_len[0] = 3;
    do_reset();
    data[0] = {8'h44, 8'h33, 8'h22, 8'h11};
    sent_q.delete();
    req[0] = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, 60, id, cyc);
      chk("all4_order", id, k);
      if (id >= 0) req[0][id] = 1'b0;
    end
    chk("all4_nstrobe", sent_q.size(), 8);
    for (int k = 0; k < 4; k++) begin
      chk("all4_hdr", sent_q[2*k], 8'hA0 | 8'(k));
      chk("all4_pay", sent_q[2*k+1], 8'h11 * 8'(k + 1));
    end

    // Serve 1 alone (ptr -> 2), then 0 and 3 held: 3,0,3,0
    busy_len[0] = 2;
    req[0] = 4'b0010;
    wait_ack(0, 60, id, cyc);
    chk("rr_single", id, 1);
    req[0] = '0;
    @(negedge clk);
    sent_q.delete();
    req[0] = 4'b1001;
    exp_hdr = '{8'hA3, 8'hA0, 8'hA3, 8'hA0};
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, 60, id, cyc);
      chk("fair_order", id, (k % 2 == 0) ? 3 : 0);
    end
    req[0] = '0;
    for (int k = 0; k < 4; k++) chk("fair_hdr", sent_q[2*k], exp_hdr[k]);
    @(negedge clk);

    // Timeout: busy never rises
    busy_len[0] = 0;
    sent_q.delete();
    data[0][2] = 8'h77;
    req[0] = 4'b0100;
    wait_ack(0, 40, id, cyc);
    chk("to_ack_id", id, 2);
    chk("to_ack_cycle", cyc, 10);
    chk("to_err_set", err[0], 1);
    req[0] = '0;
    chk("to_nstrobe", sent_q.size(), 1);
    chk("to_hdr", sent_q[0], 8'hA2);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", err[0], 1);
    // Clear held high across a second timeout: set wins on coincidence
    eclr[0] = 1'b1;
    req[0] = 4'b0001;
    @(negedge clk);
    chk("to_err_cleared", err[0], 0);
    wait_ack(0, 40, id, cyc);
    chk("to2_ack_cycle", cyc, 9);
    chk("to2_set_wins", err[0], 1);
    eclr[0] = 1'b0;
    req[0] = '0;
    @(negedge clk);
    chk("to2_err_hold", err[0], 1);
    eclr[0] = 1'b1;
    @(negedge clk);
    eclr[0] = 1'b0;
    chk("err_clr_pulse", err[0], 0);

    // Reset during DAT_WAIT; rr_ptr is 1 here, so 0101 picks 0 only if ptr reset
    busy_len[0] = 4;
    data[0][2] = 8'h11;
    req[0] = 4'b0100;
    repeat (9) @(negedge clk);
    chk("mid_ldata_pre", ldata[0], 8'h11);
    rst_n = 1'b0;
    req[0] = 4'b0101;
    #1;
    chk("mid_ack", ack[0], 0);
    chk("mid_grant", grant[0], 0);
    chk("mid_send", send[0], 0);
    chk("mid_ldata", ldata[0], 0);
    chk("mid_active", active[0], 0);
    sent_q.delete();
    @(negedge clk);
    chk("mid_ack_hold", ack[0], 0);
    rst_n = 1'b1;
    wait_ack(0, 60, id, cyc);
    chk("mid_rearb_id", id, 0);
    chk("mid_rearb_hdr", sent_q[0], 8'hA0);
    req[0][0] = 1'b0;
    wait_ack(0, 60, id, cyc);
    chk("mid_next_id", id, 2);
    req[0] = '0;
    @(negedge clk);

    chk("no_adjacent_strobe", adj_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/interfpga_tx_scheduler.md
Name: interfpga_tx_scheduler

Overview:
Shares one interfpga_send nibble link between NUM_REQ on-chip byte requesters. A round-robin arbiter picks one requester. The block then frames the byte: an optional header byte carrying the requester ID, followed by the payload byte. It sequences the single-cycle send strobe and busy-wait of the link transmitter, and returns a per-requester ack. It sits between the application clients and interfpga_send on the transmitting FPGA.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
HEADER_EN, 1, 1 = send header byte {HDR_MAGIC, id} before payload; 0 = payload only
TIMEOUT, 8, max cycles after a send strobe to wait for link_busy_i to rise before declaring error

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_i  in  NUM_REQ  per-requester request, level, held until matching ack_o
data_i  in  8*NUM_REQ  per-requester payload byte; requester k uses bits [8k+7:8k]
ack_o  out  NUM_REQ  one-cycle pulse to the served requester at transaction end
grant_o  out  NUM_REQ  one-hot, high for the owner from grant until ack inclusive
link_data_o  out  8  byte to interfpga_send data; held stable from strobe until busy falls
link_send_o  out  1  one-cycle send strobe to interfpga_send
link_busy_i  in  1  busy from interfpga_send
active_o  out  1  high whenever state != IDLE
err_o  out  1  sticky timeout flag
err_clr_i  in  1  synchronous clear of err_o

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, all outputs 0, including link_data_o=8'h00. Reset mid-transaction aborts without ack. The link transmitter is reset by the same net.
- States: IDLE, HDR_SEND, HDR_WAIT, DAT_SEND, DAT_WAIT, DONE.
- IDLE: if any req_i bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - Latch id and data_i[id].
  - Set grant_o.
  - Next state is HDR_SEND if HEADER_EN, else DAT_SEND.
- HDR_SEND / DAT_SEND: link_send_o=1 for exactly this one cycle.
  - link_data_o = {4'hA, id zero-extended to 4 bits} in HDR_SEND, or the latched payload in DAT_SEND.
  - Clear seen_busy and the timeout counter; go to the matching *_WAIT state.
- *_WAIT: set seen_busy when link_busy_i=1. Leave when seen_busy=1 and link_busy_i=0.
  - HDR_WAIT exits to DAT_SEND; DAT_WAIT exits to DONE.
  - If seen_busy is still 0 after TIMEOUT cycles in *_WAIT, set err_o and go to DONE. The remaining byte is not sent.
- DONE: ack_o[id]=1 for one cycle; rr_ptr = (id+1) mod NUM_REQ; return to IDLE.
- link_send_o is never asserted in two consecutive cycles. The transmitter re-arms if send stays high, so a strobe must be a single cycle.
- Payload is captured at grant. Changes to data_i[id] or deassertion of req_i[id] after grant are ignored, and the transfer completes.
- A requester still holding req_i after its ack competes again from the updated rr_ptr. Other pending requesters therefore win first.
- Nominal latency with HEADER_EN=1 and a 4-cycle busy:
  - req seen at t0; header strobe at t1; busy t2–t5; payload strobe at t7; busy t8–t11; ack at t13; IDLE at t14.
  - Back-to-back grants are possible from t14.
- err_o: sticky until err_clr_i. If err_clr_i and a new timeout coincide, set wins.
- req_i bits for ids >= NUM_REQ do not exist. Widths of id and rr_ptr are clog2(NUM_REQ), minimum 1.

Decomposition:
- Shared package interfpga_pkg holds:
  - HDR_MAGIC = 4'hA
  - the state encoding constants of this FSM
  - BYTE_W = 8
- One natural sub-module: interfpga_rr_pick. It is combinational: req vector plus rr_ptr in, one-hot grant plus id and any_req out. It is reusable for the receive-side demux later.

Test Plan:
1. Single requester: req_i=4'b0010, data_i[1]=8'h5C, bus model busy 4 cycles after strobe → link bytes 8'hA1 then 8'h5C; ack_o=4'b0010 at t13; rr_ptr=2.
2. All four requesters request simultaneously and hold until acked → service order 0,1,2,3 with headers A0,A1,A2,A3; exactly one ack per requester; link_send_o never high in two adjacent cycles.
3. Fairness: requesters 0 and 3 re-assert immediately after each ack → grants alternate 0,3,0,3; neither starves.
4. Timeout: bus model never raises busy → err_o=1 after TIMEOUT cycles in HDR_WAIT; ack still pulses; no payload strobe; err_clr_i pulse clears err_o.
5. Reset mid-operation: reset_n low during DAT_WAIT → all outputs 0 immediately with no ack; after release, pending req_i is re-arbitrated from rr_ptr=0.
6. HEADER_EN=0: req_i[2] with data 8'hFF → single strobe with link_data_o=8'hFF; ack at t7.
